// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings shared by the ALU, its shifter and the bench
package alu_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [SEL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - ALU operand/result bundle; status flags present only with ALU_FLAGS_EN
interface alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic [WIDTH-1:0] y;
    logic             out_valid;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             carry;
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, sel,
`ifdef ALU_FLAGS_EN
        input  zero, carry, ovf,
`endif
        input  y, out_valid
    );

    modport slave (
        input  in_valid, a, b, sel,
`ifdef ALU_FLAGS_EN
        output zero, carry, ovf,
`endif
        output y, out_valid
    );
endinterface

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational barrel shifter covering SLL, SRL and SRA
module alu_shifter
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a << shamt;
        case (op)
            ALU_SRL: y = a >> shamt;
            ALU_SRA: y = $unsigned($signed(a) >>> shamt);
            default: ;
        endcase
    end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered WIDTH-bit execute-stage ALU, one-cycle latency
// Optional zero/carry/ovf status registers are built when ALU_FLAGS_EN is defined.
module alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic  clk,
    input logic  rst_n,
    alu_if.slave bus
);

    alu_op_e          op;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] res;

    assign op = alu_op_e'(bus.sel);

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] add_ext;
    logic [WIDTH:0] sub_ext;
    logic           carry_nxt;
    logic           ovf_nxt;

    // Subtraction as a + ~b + 1 so bit WIDTH reads directly as "no borrow".
    assign add_ext = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign add_res = add_ext[WIDTH-1:0];
    assign sub_res = sub_ext[WIDTH-1:0];

    always_comb begin
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        case (op)
            ALU_ADD: begin
                carry_nxt = add_ext[WIDTH];
                ovf_nxt   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (add_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                carry_nxt = sub_ext[WIDTH];
                ovf_nxt   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (sub_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: ;
        endcase
    end
`else
    assign add_res = bus.a + bus.b;
    assign sub_res = bus.a - bus.b;
`endif

    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .a     (bus.a),
        .shamt (bus.b[SHW-1:0]),
        .op    (op),
        .y     (sh_res)
    );

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:                   res = add_res;
            ALU_SUB:                   res = sub_res;
            ALU_AND:                   res = bus.a & bus.b;
            ALU_OR:                    res = bus.a | bus.b;
            ALU_XOR:                   res = bus.a ^ bus.b;
            ALU_SLL, ALU_SRL, ALU_SRA: res = sh_res;
            default:                   res = '0;
        endcase
    end

    // Idle cycles keep y and flags so downstream logic can still read the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y         <= '0;
            bus.out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
            bus.zero      <= 1'b0;
            bus.carry     <= 1'b0;
            bus.ovf       <= 1'b0;
`endif
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y     <= res;
`ifdef ALU_FLAGS_EN
                bus.zero  <= (res == '0);
                bus.carry <= carry_nxt;
                bus.ovf   <= ovf_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for alu; flag checks enabled by ALU_FLAGS_EN
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input alu_op_e op);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sel      = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.y !== 32'h0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_init y=%h ov=%b exp y=0 ov=0", bus.y, bus.out_valid);
        end
        rst_n = 1'b1;
        apply(32'd15, 32'd5, ALU_ADD);
        tests++;
        if (bus.y !== 32'd20 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_preload y=%h ov=%b exp y=00000014 ov=1", bus.y, bus.out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.y !== 32'h0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_async y=%h ov=%b exp y=0 ov=0", bus.y, bus.out_valid);
        end
`ifdef ALU_FLAGS_EN
        tests++;
        if ({bus.zero, bus.carry, bus.ovf} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags zco=%b exp 000", {bus.zero, bus.carry, bus.ovf});
        end
`endif
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.y !== 32'h0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle y=%h ov=%b exp y=0 ov=0", bus.y, bus.out_valid);
        end
    endtask

    task automatic test_arith;
        logic [31:0] ta [3] = '{32'd15, 32'd15, 32'd0};
        logic [31:0] tb [3] = '{32'd5, 32'd7, 32'd1};
        alu_op_e     to [3] = '{ALU_ADD, ALU_SUB, ALU_SUB};
        logic [31:0] ty [3] = '{32'd20, 32'd8, 32'hFFFF_FFFF};
        logic        tc [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            apply(ta[i], tb[i], to[i]);
            tests++;
            if (bus.y !== ty[i] || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL arith[%0d] y=%h ov=%b exp y=%h ov=1", i, bus.y, bus.out_valid, ty[i]);
            end
`ifdef ALU_FLAGS_EN
            tests++;
            if (bus.carry !== tc[i] || bus.ovf !== 1'b0 || bus.zero !== 1'b0) begin
                fails++;
                $display("FAIL arith_flags[%0d] c=%b v=%b z=%b exp c=%b v=0 z=0",
                         i, bus.carry, bus.ovf, bus.zero, tc[i]);
            end
`else
            if (tc[i] === 1'bx) $display("unreachable");
`endif
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_logic;
        logic [31:0] ta [3] = '{32'hFFFF_0000, 32'hAAAA_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [3] = '{32'h00FF_00FF, 32'h5555_0000, 32'h0000_FFFF};
        alu_op_e     to [3] = '{ALU_AND, ALU_OR, ALU_XOR};
        logic [31:0] ty [3] = '{32'h00FF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
        for (int i = 0; i < 3; i++) begin
            apply(ta[i], tb[i], to[i]);
            tests++;
            if (bus.y !== ty[i] || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL logic[%0d] y=%h ov=%b exp y=%h ov=1", i, bus.y, bus.out_valid, ty[i]);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_shift;
        logic [31:0] tb [6] = '{32'd4, 32'd4, 32'd4, 32'd32, 32'd32, 32'd32};
        alu_op_e     to [6] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLL, ALU_SRL, ALU_SRA};
        logic [31:0] ty [6] = '{32'h0000_0010, 32'h0800_0000, 32'hF800_0000,
                                32'h8000_0001, 32'h8000_0001, 32'h8000_0001};
        for (int i = 0; i < 6; i++) begin
            apply(32'h8000_0001, tb[i], to[i]);
            tests++;
            if (bus.y !== ty[i] || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL shift[%0d] y=%h ov=%b exp y=%h ov=1", i, bus.y, bus.out_valid, ty[i]);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [5] = '{32'd100, 32'd100, 32'h0000_00F0, 32'h0000_0001, 32'hFFFF_FF00};
        logic [31:0] tb [5] = '{32'd23, 32'd1, 32'h0000_003C, 32'd31, 32'd8};
        alu_op_e     to [5] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_SLL, ALU_SRA};
        logic [31:0] ty [5] = '{32'd123, 32'd99, 32'h0000_0030, 32'h8000_0000, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            apply(ta[i], tb[i], to[i]);
            tests++;
            if (bus.y !== ty[i] || bus.out_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d] y=%h ov=%b exp y=%h ov=1", i, bus.y, bus.out_valid, ty[i]);
            end
        end
        bus.in_valid = 1'b0;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h1111_1111;
        bus.sel      = ALU_ADD;
        @(posedge clk);
        #1;
        tests++;
        if (bus.y !== 32'hFFFF_FFFF || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold y=%h ov=%b exp y=ffffffff ov=0", bus.y, bus.out_valid);
        end
    endtask

`ifdef ALU_FLAGS_EN
    task automatic test_flags;
        logic [31:0] ta [3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00F0};
        logic [31:0] tb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_000F};
        alu_op_e     to [3] = '{ALU_ADD, ALU_ADD, ALU_AND};
        logic [31:0] ty [3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
        logic [2:0]  tf [3] = '{3'b001, 3'b110, 3'b100};
        for (int i = 0; i < 3; i++) begin
            apply(ta[i], tb[i], to[i]);
            tests++;
            if (bus.y !== ty[i] || {bus.zero, bus.carry, bus.ovf} !== tf[i]) begin
                fails++;
                $display("FAIL flags[%0d] y=%h zco=%b exp y=%h zco=%b",
                         i, bus.y, {bus.zero, bus.carry, bus.ovf}, ty[i], tf[i]);
            end
        end
        bus.in_valid = 1'b0;
    endtask
`endif

    initial begin
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sel      = ALU_ADD;
        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_back_to_back();
`ifdef ALU_FLAGS_EN
        test_flags();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1);
    end

endmodule
